cv32e40p_apu_arbiter: RTL and testbench
=======================================

Name: cv32e40p_apu_arbiter

Overview:
- Shares one FPU wrapper (APU slave interface) between NUM_REQ cores' APU master ports.
- Round-robin arbitration on issue. An in-order ID FIFO routes each result back to the core that issued it.
- Sits between the cores and the single FPU clock gate plus FPU wrapper, in a cluster build with a shared FPU.
- Also produces the FPU clock-gate enable.

Parameters:
- NUM_REQ, 2, number of requesting cores (2..8).
- MAX_OUTSTANDING, 4, ID FIFO depth, i.e. maximum FPU operations in flight (1..8). Must be 1 unless FPU_ADDMUL_LAT == FPU_OTHERS_LAT, because results must return in issue order.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- apu_req_i  in  NUM_REQ  per-core request
- apu_gnt_o  out  NUM_REQ  per-core grant
- apu_operands_i  in  NUM_REQ x APU_NARGS_CPU x 32  per-core operands (3x32)
- apu_op_i  in  NUM_REQ x APU_WOP_CPU  per-core opcode (6)
- apu_flags_i  in  NUM_REQ x APU_NDSFLAGS_CPU  per-core downstream flags (15)
- apu_rvalid_o  out  NUM_REQ  per-core result valid
- apu_result_o  out  32  result data, broadcast to all cores
- apu_rflags_o  out  APU_NUSFLAGS_CPU  result flags (5), broadcast
- fpu_req_o  out  1  request to FPU
- fpu_gnt_i  in  1  FPU grant
- fpu_operands_o  out  APU_NARGS_CPU x 32  muxed operands
- fpu_op_o  out  APU_WOP_CPU  muxed opcode
- fpu_flags_o  out  APU_NDSFLAGS_CPU  muxed flags
- fpu_rvalid_i  in  1  FPU result valid
- fpu_result_i  in  32  FPU result
- fpu_rflags_i  in  APU_NUSFLAGS_CPU  FPU result flags
- busy_o  out  1  FPU clock-gate enable
- err_o  out  1  sticky: rvalid received with ID FIFO empty

Behaviour:
- Clocking and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset state of registers: rr_ptr=0, lock=0, lock_idx=0, FIFO empty (count=0), err_o=0.
- Reset value of outputs: all outputs 0, except apu_result_o, apu_rflags_o, fpu_operands_o, fpu_op_o and fpu_flags_o, which are 0 only because they mux from 0 inputs.
- Winner selection, when not locked: first asserted apu_req_i at or after rr_ptr, wrapping modulo NUM_REQ.
- Winner selection, when locked: winner = lock_idx.
- fpu_req_o = any request asserted AND count < MAX_OUTSTANDING. The count<MAX_OUTSTANDING term also holds when count==MAX_OUTSTANDING but an FPU pop occurs in the same cycle.
- fpu_operands_o, fpu_op_o and fpu_flags_o are combinationally muxed from the winner.
- apu_gnt_o[winner] = fpu_gnt_i & fpu_req_o. All other grants are 0.
- Grant path is zero latency, combinational, with no bubble.
- Handshake occurs when fpu_req_o & fpu_gnt_i. On handshake:
  - push winner index into the ID FIFO;
  - rr_ptr <= (winner+1) mod NUM_REQ;
  - lock <= 0.
- Lock: if fpu_req_o & !fpu_gnt_i, then lock <= 1 and lock_idx <= winner. This keeps the FPU request stable as the APU protocol requires.
  - The lock persists until handshake.
  - Locked requests are never dropped.
  - The locked core must hold apu_req_i high. If it does not, lock clears and the request is treated as a protocol violation (not checked).
- FIFO full (count == MAX_OUTSTANDING) with no pop that cycle:
  - fpu_req_o=0 and no grants;
  - the lock flag is unchanged.
- Result routing: on fpu_rvalid_i, apu_rvalid_o[fifo_head] = 1 in the same cycle (combinational) and the FIFO pops.
  - apu_result_o = fpu_result_i and apu_rflags_o = fpu_rflags_i, both unregistered.
- Simultaneous push and pop: count unchanged. The pop reads the head before the push; with count==0 the pushed entry is not the one popped.
- fpu_rvalid_i with count==0: no apu_rvalid_o asserted, err_o <= 1 (sticky until reset), count stays 0.
- busy_o = fpu_req_o | (count != 0). This keeps the FPU clock running until the last result returns.
- Reset mid-operation clears everything. Any in-flight results arriving afterwards set err_o.

Decomposition:
- cv32e40p_apu_core_pkg supplies APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU and APU_NUSFLAGS_CPU (reused unchanged).
- Add to the same package: localparam APU_ARB_MAX_REQ=8 and typedef apu_arb_idx_t = logic [2:0].
- Sub-module cv32e40p_apu_arb_id_fifo:
  - circular buffer with DEPTH=MAX_OUTSTANDING, WIDTH=$clog2(NUM_REQ);
  - ports: push, pop, wdata, rdata, count, full, empty;
  - same-cycle push and pop both take effect.

Test Plan:
- Single core, FPU grants immediately. Core0 issues 3 ops on consecutive cycles; fpu_rvalid_i returns 4 cycles later with results 0x3F800000, 0x40000000, 0x40400000 -> apu_gnt_o=01 on each cycle; apu_rvalid_o=01 with matching results; busy_o falls 1 cycle after the last rvalid.
- Both cores request continuously, fpu_gnt_i=1 -> grants alternate 01,10,01,10; ID FIFO order 0,1,0,1; rvalid routes to cores 0,1,0,1.
- Core1 wins while fpu_gnt_i=0 for 3 cycles, and core0 asserts request meanwhile -> fpu_op_o/operands are stable at core1's values for all 3 cycles; grant goes to core1 only, then core0 is granted next.
- MAX_OUTSTANDING=2, no rvalid. Four requests -> only 2 grants, then fpu_req_o=0. A single rvalid then frees one slot and a third grant occurs in the same cycle as the pop.
- fpu_rvalid_i pulsed with FIFO empty -> no apu_rvalid_o; err_o=1 and it holds until rst_ni low.
- Assert rst_ni=0 asynchronously with 2 ops outstanding -> all outputs 0 immediately, count=0, rr_ptr=0.

Source files
------------

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared by the cores and the FPU wrapper, plus the
// index type used when arbitrating several cores onto one FPU.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  localparam int APU_ARB_MAX_REQ  = 8;
  typedef logic [2:0] apu_arb_idx_t;

endpackage

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// In-order FIFO of issuing-core indices; a push and a pop in the same cycle
// both take effect, so a full FIFO can accept a push while it is being popped.
module cv32e40p_apu_arb_id_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one FPU between NUM_REQ cores: round-robin issue with a lock that
// holds a stalled request stable, and an ID FIFO that routes results back.
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic [NUM_REQ-1:0]                             apu_req_i,
  output logic [NUM_REQ-1:0]                             apu_gnt_o,
  input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]    apu_operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]            apu_op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]       apu_flags_i,
  output logic [NUM_REQ-1:0]                             apu_rvalid_o,
  output logic [31:0]                                    apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                    apu_rflags_o,
  output logic                                           fpu_req_o,
  input  logic                                           fpu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]                 fpu_operands_o,
  output logic [APU_WOP_CPU-1:0]                         fpu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                    fpu_flags_o,
  input  logic                                           fpu_rvalid_i,
  input  logic [31:0]                                    fpu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                    fpu_rflags_i,
  output logic                                           busy_o,
  output logic                                           err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_idx;
  logic          lock;
  logic [IW-1:0] winner;
  logic [IW-1:0] winner_inc;
  logic [IW-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          any_req;
  logic          room;
  logic          handshake;

  // Upper half (at/after rr_ptr) is scanned last so it overrides the lower half.
  always_comb begin
    winner = rr_ptr;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (apu_req_i[j] && (j < int'(rr_ptr))) winner = IW'(j);
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (apu_req_i[j] && (j >= int'(rr_ptr))) winner = IW'(j);
    end
    if (lock) winner = lock_idx;
  end

  assign winner_inc = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign any_req    = lock ? apu_req_i[lock_idx] : |apu_req_i;
  assign fifo_pop   = fpu_rvalid_i & ~fifo_empty;
  assign room       = ~fifo_full | fifo_pop;
  assign fpu_req_o  = any_req & room;
  assign handshake  = fpu_req_o & fpu_gnt_i;

  assign apu_gnt_o      = handshake ? (NUM_REQ'(1) << winner) : '0;
  assign fpu_operands_o = apu_operands_i[winner];
  assign fpu_op_o       = apu_op_i[winner];
  assign fpu_flags_o    = apu_flags_i[winner];

  assign apu_rvalid_o = fifo_pop ? (NUM_REQ'(1) << fifo_rdata) : '0;
  assign apu_result_o = fpu_result_i;
  assign apu_rflags_o = fpu_rflags_i;
  assign busy_o       = fpu_req_o | (fifo_count != '0);

  // A full FIFO drops fpu_req_o, so neither branch below fires and lock holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err_o    <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= winner_inc;
        lock   <= 1'b0;
      end else if (fpu_req_o) begin
        lock     <= 1'b1;
        lock_idx <= winner;
      end else if (lock && !apu_req_i[lock_idx]) begin
        lock <= 1'b0;
      end
      if (fpu_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  cv32e40p_apu_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .pop    (fifo_pop),
    .wdata  (winner),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Cycle table for the two-core arbiter with a scoreboard of issuing cores,
// followed by hand-written error-flag and asynchronous-reset sequences.
module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int MAX_OUT = 4;
  localparam logic [APU_WOP_CPU-1:0]      OP0 = 6'h05;
  localparam logic [APU_WOP_CPU-1:0]      OP1 = 6'h2A;
  localparam logic [APU_NDSFLAGS_CPU-1:0] FL0 = 15'h0011;
  localparam logic [APU_NDSFLAGS_CPU-1:0] FL1 = 15'h0A22;

  logic                                        clk_i = 1'b0;
  logic                                        rst_ni;
  logic [NUM_REQ-1:0]                          apu_req_i;
  logic [NUM_REQ-1:0]                          apu_gnt_o;
  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] apu_operands_i;
  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]         apu_op_i;
  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    apu_flags_i;
  logic [NUM_REQ-1:0]                          apu_rvalid_o;
  logic [31:0]                                 apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]                 apu_rflags_o;
  logic                                        fpu_req_o;
  logic                                        fpu_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0]              fpu_operands_o;
  logic [APU_WOP_CPU-1:0]                      fpu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]                 fpu_flags_o;
  logic                                        fpu_rvalid_i;
  logic [31:0]                                 fpu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0]                 fpu_rflags_i;
  logic                                        busy_o;
  logic                                        err_o;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] res;
    logic [1:0]  expGnt;
    logic        expReq;
    logic        expBusy;
    int          expWin;
  } vec_t;

  vec_t vecs[$];
  int   sbQueue[$];
  int   errCount   = 0;
  int   checkCount = 0;

  always #5 clk_i = ~clk_i;

  cv32e40p_apu_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .apu_req_i      (apu_req_i),
    .apu_gnt_o      (apu_gnt_o),
    .apu_operands_i (apu_operands_i),
    .apu_op_i       (apu_op_i),
    .apu_flags_i    (apu_flags_i),
    .apu_rvalid_o   (apu_rvalid_o),
    .apu_result_o   (apu_result_o),
    .apu_rflags_o   (apu_rflags_o),
    .fpu_req_o      (fpu_req_o),
    .fpu_gnt_i      (fpu_gnt_i),
    .fpu_operands_o (fpu_operands_o),
    .fpu_op_o       (fpu_op_o),
    .fpu_flags_o    (fpu_flags_o),
    .fpu_rvalid_i   (fpu_rvalid_i),
    .fpu_result_i   (fpu_result_i),
    .fpu_rflags_i   (fpu_rflags_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  function automatic vec_t mk(input logic [1:0] req, input logic gnt, input logic rv,
                              input logic [31:0] res, input logic [1:0] expGnt,
                              input logic expReq, input logic expBusy, input int expWin = -1);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.res = res;
    v.expGnt = expGnt; v.expReq = expReq; v.expBusy = expBusy; v.expWin = expWin;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv,
                               input logic [31:0] res);
    apu_req_i    = req;
    fpu_gnt_i    = gnt;
    fpu_rvalid_i = rv;
    fpu_result_i = res;
    fpu_rflags_i = res[4:0] ^ 5'h15;
  endtask

  // One table row: drive after the edge, compare at the falling edge, then
  // pop the scoreboard on a result and push the expected issuing core on a grant.
  task automatic runVector(input vec_t v, input int idx);
    logic [1:0] expRv;
    @(posedge clk_i); #1;
    applyStimulus(v.req, v.gnt, v.rv, v.res);
    #4;
    checkOutput($sformatf("row%0d gnt", idx), 32'(apu_gnt_o), 32'(v.expGnt));
    checkOutput($sformatf("row%0d fpu_req", idx), 32'(fpu_req_o), 32'(v.expReq));
    checkOutput($sformatf("row%0d busy", idx), 32'(busy_o), 32'(v.expBusy));
    if (v.expWin >= 0) begin
      checkOutput($sformatf("row%0d op", idx), 32'(fpu_op_o), 32'(v.expWin == 1 ? OP1 : OP0));
      checkOutput($sformatf("row%0d flags", idx), 32'(fpu_flags_o), 32'(v.expWin == 1 ? FL1 : FL0));
      checkOutput($sformatf("row%0d opnd2", idx), fpu_operands_o[2], 32'h1000 * (v.expWin + 1) + 2);
    end
    expRv = 2'b00;
    if (v.rv) begin
      if (sbQueue.size() > 0) expRv = 2'b01 << sbQueue.pop_front();
      checkOutput($sformatf("row%0d result", idx), apu_result_o, v.res);
      checkOutput($sformatf("row%0d rflags", idx), 32'(apu_rflags_o), 32'(v.res[4:0] ^ 5'h15));
    end
    checkOutput($sformatf("row%0d rvalid", idx), 32'(apu_rvalid_o), 32'(expRv));
    if (v.expGnt != 2'b00) sbQueue.push_back(v.expGnt[1] ? 1 : 0);
  endtask

  initial begin
    for (int c = 0; c < NUM_REQ; c++) begin
      for (int k = 0; k < APU_NARGS_CPU; k++) apu_operands_i[c][k] = 32'h1000 * (c + 1) + k;
    end
    apu_op_i    = {OP1, OP0};
    apu_flags_i = {FL1, FL0};
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b0;

    #2;
    checkOutput("reset fpu_req", 32'(fpu_req_o), 32'h0);
    checkOutput("reset gnt", 32'(apu_gnt_o), 32'h0);
    checkOutput("reset rvalid", 32'(apu_rvalid_o), 32'h0);
    checkOutput("reset busy", 32'(busy_o), 32'h0);
    checkOutput("reset err", 32'(err_o), 32'h0);
    checkOutput("reset op mux", 32'(fpu_op_o), 32'(OP0));
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Single core, three back-to-back ops, results four cycles after issue.
    vecs.push_back(mk(2'b01, 1, 0, 32'h0,        2'b01, 1, 1));
    vecs.push_back(mk(2'b01, 1, 0, 32'h0,        2'b01, 1, 1));
    vecs.push_back(mk(2'b01, 1, 0, 32'h0,        2'b01, 1, 1));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 1));
    vecs.push_back(mk(2'b00, 0, 1, 32'h3F800000, 2'b00, 0, 1));
    vecs.push_back(mk(2'b00, 0, 1, 32'h40000000, 2'b00, 0, 1));
    vecs.push_back(mk(2'b00, 0, 1, 32'h40400000, 2'b00, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 0));
    // Both cores continuously requesting; pointer now sits at core 1.
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b10, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b01, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b10, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b01, 1, 1));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(2'b00, 0, 1, 32'hB0000000 + k, 2'b00, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 0));
    // Move the pointer to core 0, then core 1 stalls: the lock must keep it.
    vecs.push_back(mk(2'b10, 1, 0, 32'h0,        2'b10, 1, 1));
    vecs.push_back(mk(2'b10, 0, 0, 32'h0,        2'b00, 1, 1, 1));
    vecs.push_back(mk(2'b11, 0, 0, 32'h0,        2'b00, 1, 1, 1));
    vecs.push_back(mk(2'b11, 0, 0, 32'h0,        2'b00, 1, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b10, 1, 1, 1));
    vecs.push_back(mk(2'b01, 1, 0, 32'h0,        2'b01, 1, 1, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(2'b00, 0, 1, 32'hC0000000 + k, 2'b00, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 0));
    // Fill the ID FIFO, stall while full, then a pop frees a slot the same cycle.
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b10, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b01, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b10, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b01, 1, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b00, 0, 1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h0,        2'b00, 0, 1));
    vecs.push_back(mk(2'b11, 1, 1, 32'hD0000000, 2'b10, 1, 1));
    for (int k = 1; k < 5; k++) vecs.push_back(mk(2'b00, 0, 1, 32'hD0000000 + k, 2'b00, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 0));

    for (int i = 0; i < vecs.size(); i++) runVector(vecs[i], i);
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'h0);
    checkOutput("no spurious err", 32'(err_o), 32'h0);

    // Result with nothing outstanding: no routing, sticky error flag.
    @(posedge clk_i); #1;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hE0000000);
    #4 checkOutput("orphan rvalid", 32'(apu_rvalid_o), 32'h0);
    @(posedge clk_i); #1;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    #4 checkOutput("err set", 32'(err_o), 32'h1);
    repeat (3) @(posedge clk_i);
    #5 checkOutput("err sticky", 32'(err_o), 32'h1);
    rst_ni = 1'b0;
    #1 checkOutput("err cleared by reset", 32'(err_o), 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // Two ops in flight, then an asynchronous reset mid-cycle.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
      #4 checkOutput($sformatf("pre-reset gnt%0d", k), 32'(apu_gnt_o), 32'h1);
    end
    @(posedge clk_i); #1;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    #2 checkOutput("busy before reset", 32'(busy_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(busy_o), 32'h0);
    checkOutput("async reset fpu_req", 32'(fpu_req_o), 32'h0);
    checkOutput("async reset gnt", 32'(apu_gnt_o), 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hF0000000);
    #4 checkOutput("late result not routed", 32'(apu_rvalid_o), 32'h0);
    @(posedge clk_i); #1;
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
    #4;
    checkOutput("late result err", 32'(err_o), 32'h1);
    checkOutput("rr_ptr reset to core0", 32'(apu_gnt_o), 32'h1);
    @(posedge clk_i); #1;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
